// File: rtl/cmp_iter_if.sv
// Handshake and operand/result bundle for the iterative magnitude comparator.
// The master side issues operands and consumes results; the slave side is the comparator.
interface cmp_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [WIDTH-1:0] max_o;
    logic [WIDTH-1:0] min_o;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, lt, eq, gt, max_o, min_o
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, lt, eq, gt, max_o, min_o
    );
endinterface

// File: rtl/cmp_iter.sv
// Iterative magnitude comparator: scans SLICE bits per cycle from the MSB down and stops
// at the first differing slice, returning one-hot lt/eq/gt plus the max and min operand.
module cmp_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input logic       clk,
    input logic       rst,
    cmp_iter_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("cmp_iter: WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   ka_q, kb_q;
    logic               out_valid_q;
    logic               lt_q, eq_q, gt_q;
    logic [WIDTH-1:0]   max_q, min_q;
    logic [SLICE-1:0]   slice_a, slice_b;

    always_comb begin
        slice_a = ka_q[int'(idx_q) * SLICE +: SLICE];
        slice_b = kb_q[int'(idx_q) * SLICE +: SLICE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ka_q        <= '0;
            kb_q        <= '0;
            out_valid_q <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        // Flipping the sign bit maps two's-complement order onto unsigned order
                        ka_q    <= bus.is_signed ? (bus.a ^ MSB_MASK) : bus.a;
                        kb_q    <= bus.is_signed ? (bus.b ^ MSB_MASK) : bus.b;
                        idx_q   <= IDX_W'(NSLICE - 1);
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    if (slice_a != slice_b) begin
                        if (slice_a < slice_b) begin
                            lt_q  <= 1'b1;
                            max_q <= b_q;
                            min_q <= a_q;
                        end else begin
                            gt_q  <= 1'b1;
                            max_q <= a_q;
                            min_q <= b_q;
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else if (idx_q == '0) begin
                        eq_q        <= 1'b1;
                        max_q       <= a_q;
                        min_q       <= a_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        lt_q        <= 1'b0;
                        eq_q        <= 1'b0;
                        gt_q        <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // in_ready must drop while rst is held, even though the state already reads idle
    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.max_o     = max_q;
    assign bus.min_o     = min_q;
endmodule

// File: tb/tb_cmp_iter.sv
// Directed bench for cmp_iter: SLICE=8 for handshake, backpressure and reset cases,
// SLICE=32 and SLICE=1 side by side for latency and result sweeps.
module tb_cmp_iter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    cmp_iter_if #(.WIDTH(32)) if8 ();
    cmp_iter_if #(.WIDTH(32)) if32 ();
    cmp_iter_if #(.WIDTH(32)) if1 ();

    cmp_iter #(.WIDTH(32), .SLICE(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    cmp_iter #(.WIDTH(32), .SLICE(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    cmp_iter #(.WIDTH(32), .SLICE(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation on the SLICE=8 unit from a negedge; returns at the negedge
    // after out_valid is seen, leaving the result in DONE.
    task automatic issue8(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat);
        check("in_ready_before_issue", 32'(if8.in_ready), 32'd1);
        if8.in_valid  = 1'b1;
        if8.a         = a;
        if8.b         = b;
        if8.is_signed = s;
        @(posedge clk);
        @(negedge clk);
        if8.in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if8.out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic retire8();
        if8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.out_ready = 1'b0;
        check("retire_out_valid", 32'(if8.out_valid), 32'd0);
        check("retire_in_ready", 32'(if8.in_ready), 32'd1);
    endtask

    task automatic op8(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [2:0] exp_lge, input logic [31:0] exp_max,
                       input logic [31:0] exp_min, input int exp_lat);
        int lat;
        issue8(a, b, s, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_flags"}, 32'({if8.lt, if8.eq, if8.gt}), 32'(exp_lge));
        check({tag, "_max"}, if8.max_o, exp_max);
        check({tag, "_min"}, if8.min_o, exp_min);
        retire8();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [2:0]  lge;
        logic [31:0] mx;
        logic [31:0] mn;
        int          lat1;
    } sweep_t;

    sweep_t sweep[8];

    task automatic sweep_op(input int n, input sweep_t v);
        int lat32;
        int lat1;
        string tag;
        tag = $sformatf("sweep%0d", n);
        if32.in_valid = 1'b1; if32.a = v.a; if32.b = v.b; if32.is_signed = v.s;
        if1.in_valid  = 1'b1; if1.a  = v.a; if1.b  = v.b; if1.is_signed  = v.s;
        @(posedge clk);
        @(negedge clk);
        if32.in_valid = 1'b0;
        if1.in_valid  = 1'b0;
        lat32 = 0;
        lat1  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (lat32 == 0 && if32.out_valid) lat32 = c;
            if (lat1 == 0 && if1.out_valid) lat1 = c;
            if (lat32 != 0 && lat1 != 0) break;
        end
        check({tag, "_lat32"}, 32'(lat32), 32'd1);
        check({tag, "_lat1"}, 32'(lat1), 32'(v.lat1));
        check({tag, "_flags32"}, 32'({if32.lt, if32.eq, if32.gt}), 32'(v.lge));
        check({tag, "_flags1"}, 32'({if1.lt, if1.eq, if1.gt}), 32'(v.lge));
        check({tag, "_max32"}, if32.max_o, v.mx);
        check({tag, "_min1"}, if1.min_o, v.mn);
        if32.out_ready = 1'b1;
        if1.out_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if32.out_ready = 1'b0;
        if1.out_ready  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        n_checks = 0;
        n_fail   = 0;
        // flags ordering is {lt, eq, gt}
        sweep[0] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 3'b001, 32'h0000_0001, 32'h0000_0000, 32};
        sweep[1] = '{32'h8000_0000, 32'h0000_0000, 1'b1, 3'b100, 32'h0000_0000, 32'h8000_0000, 1};
        sweep[2] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 3'b001, 32'h8000_0000, 32'h0000_0000, 1};
        sweep[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32};
        sweep[4] = '{32'h1234_0000, 32'h1235_0000, 1'b0, 3'b100, 32'h1235_0000, 32'h1234_0000, 16};
        sweep[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
        sweep[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1};
        sweep[7] = '{32'h0000_0400, 32'h0000_0300, 1'b0, 3'b001, 32'h0000_0400, 32'h0000_0300, 22};

        rst = 1'b1;
        if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.is_signed = 1'b0;  if8.out_ready = 1'b0;
        if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.is_signed = 1'b0; if32.out_ready = 1'b0;
        if1.in_valid = 1'b0;  if1.a = '0;  if1.b = '0;  if1.is_signed = 1'b0;  if1.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(if8.in_ready), 32'd0);
        check("rst_out_valid", 32'(if8.out_valid), 32'd0);
        check("rst_flags", 32'({if8.lt, if8.eq, if8.gt}), 32'd0);
        check("rst_max", if8.max_o, 32'd0);
        check("rst_min", if8.min_o, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(if8.in_ready), 32'd1);
        @(negedge clk);

        op8("u5v3", 32'h0000_0005, 32'h0000_0003, 1'b0, 3'b001, 32'h5, 32'h3, 4);
        op8("s_m1v1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, 32'h1, 32'hFFFF_FFFF, 1);
        op8("u_m1v1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001, 32'hFFFF_FFFF, 32'h1, 1);
        op8("s_eq", 32'h1234_5678, 32'h1234_5678, 1'b1, 3'b010, 32'h1234_5678,
            32'h1234_5678, 4);
        op8("s_minmax", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 32'h7FFF_FFFF,
            32'h8000_0000, 1);

        // Backpressure: result must hold and a new request must be ignored
        issue8(32'h0000_0100, 32'h0000_0200, 1'b0, lat);
        check("bp_lat", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                if8.in_valid = 1'b1;
                if8.a        = 32'hAAAA_AAAA;
                if8.b        = 32'h5555_5555;
            end else begin
                if8.in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(if8.out_valid), 32'd1);
            check("bp_in_ready", 32'(if8.in_ready), 32'd0);
            check("bp_flags", 32'({if8.lt, if8.eq, if8.gt}), 32'b100);
            check("bp_max", if8.max_o, 32'h0000_0200);
            check("bp_min", if8.min_o, 32'h0000_0100);
        end
        if8.in_valid = 1'b0;
        retire8();
        check("bp_flags_cleared", 32'({if8.lt, if8.eq, if8.gt}), 32'd0);
        check("bp_max_held", if8.max_o, 32'h0000_0200);
        @(negedge clk);
        check("bp_no_queued_op", 32'(if8.in_ready), 32'd1);

        // Reset during the second scan cycle discards the operation
        if8.in_valid  = 1'b1;
        if8.a         = 32'h0000_0001;
        if8.b         = 32'h0000_0002;
        if8.is_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(if8.in_ready), 32'd0);
        check("midrst_max", if8.max_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_no_valid", 32'(if8.out_valid), 32'd0);
        end
        op8("post_rst_7v9", 32'd7, 32'd9, 1'b0, 3'b100, 32'd9, 32'd7, 4);

        for (int i = 0; i < 8; i++) sweep_op(i, sweep[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cmp_iter.md
# cmp_iter

Parametrised, iterative magnitude comparator for the CPU datapath. It compares two WIDTH-bit operands, signed or unsigned per operation, scanning SLICE bits per cycle from the MSB down and stopping at the first slice that differs. It returns one-hot less/equal/greater flags plus the min and max operand. A valid/ready handshake on both sides lets it sit behind the issue stage as a variable-latency execution unit.

## Interface
- WIDTH, default 32: operand width in bits.
- SLICE, default 8: bits examined per scan cycle. WIDTH % SLICE must be 0; elaboration fails otherwise. NSLICE = WIDTH/SLICE.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  unit can accept; high only in IDLE and low while rst is high.
- a, b  input  WIDTH  operands.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- lt, eq, gt  output  1 each  one-hot result (a<b, a==b, a>b).
- max_o, min_o  output  WIDTH each  larger and smaller original operand; for eq both equal a.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: in_ready=1. When in_valid is high at an edge:
  - latch a, b unmodified for max_o/min_o;
  - latch compare keys ka/kb (operand with MSB inverted if is_signed, else unchanged), which turns the signed compare into an unsigned one;
  - idx <= NSLICE-1; go to SCAN.
- SCAN: compare slice ka[idx*SLICE +: SLICE] against kb.
  - If the slices differ, set lt or gt from the unsigned slice compare and go to DONE.
  - Else, if idx==0, set eq and go to DONE.
  - Else idx <= idx-1 and stay in SCAN.
- DONE: out_valid=1. lt/eq/gt/max_o/min_o are registered and stable for the whole state. When out_ready is high at an edge, go to IDLE and clear out_valid.
- in_valid in SCAN or DONE is ignored: no queuing and no operand overwrite.
- lt/eq/gt are all 0 outside DONE. max_o/min_o hold their last values until the next result.
- max_o/min_o selection uses the signedness latched for that operation.

## Timing
- Reset values: state IDLE, out_valid 0, lt/eq/gt 0, max_o/min_o 0, idx 0, in_ready 0 during rst then 1.
- Accept edge T. The first differing slice is at index j (top slice is NSLICE-1).
  - k = NSLICE-j scan cycles.
  - DONE is entered at edge T+k; out_valid is high from T+k.
  - Equal operands give k = NSLICE.
- Latency range: 1..NSLICE cycles. SLICE=WIDTH gives a fixed latency of 1.
- Retire edge R (out_valid & out_ready): IDLE from R, next accept no earlier than edge R+1. Minimum issue interval is k+2 cycles.
- out_ready low in DONE: everything holds indefinitely.
- out_ready high on the DONE entry cycle: retire at the next edge.
- rst asserted at any point: all registers clear asynchronously and the in-flight operation is discarded without out_valid. The first accept after rst deasserts behaves as from power-up.

## Test plan
- WIDTH=32, SLICE=8, unsigned a=0x00000005, b=0x00000003 -> out_valid 4 cycles after accept, gt=1, lt=eq=0, max_o=0x5, min_o=0x3.
- Signed a=0xFFFFFFFF, b=0x00000001 -> 1-cycle latency, lt=1, max_o=0x1, min_o=0xFFFFFFFF. Same operands unsigned -> gt=1, max_o=0xFFFFFFFF.
- a=b=0x12345678, signed -> latency 4, eq=1, max_o=min_o=0x12345678. Also signed a=0x80000000, b=0x7FFFFFFF -> lt=1 in 1 cycle.
- Backpressure: hold out_ready low 5 cycles after DONE -> out_valid and all results stable, in_ready=0, a pulsed in_valid with new operands is ignored. Raise out_ready -> retire, in_ready=1 the next cycle.
- Reset mid-SCAN (a=0x00000001, b=0x00000002, rst at 2nd scan cycle) -> out_valid never rises. After release, a=7, b=9 unsigned yields lt=1 with 4-cycle latency.
- Parameter sweep SLICE=32, SLICE=1 (WIDTH=32) on random signed/unsigned pairs against a reference model.
  - Latency is always 1 for SLICE=32 and 32-j for SLICE=1, where j is the index of the highest differing key bit, or 32 when equal.
  - Flags are always one-hot in DONE.
